// File: rtl/md_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the control state type.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_NOP   = 3'd6;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_core_div.sv
// Combinational 32-bit divider producing quotient and remainder, signed or
// unsigned, with fixed results for divide-by-zero and signed overflow.
module md_core_div (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;

  assign neg_a = is_signed & a[31];
  assign neg_b = is_signed & b[31];
  assign mag_a = neg_a ? (32'd0 - a) : a;
  assign mag_b = neg_b ? (32'd0 - b) : b;

  always_comb begin
    quo_mag = '0;
    rem_mag = '0;
    quo     = '0;
    rem     = '0;
    if (b == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = a;
    end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end else begin
      quo_mag = mag_a / mag_b;
      rem_mag = mag_a % mag_b;
      // Truncating division: quotient sign is the XOR, remainder follows the dividend.
      quo = (neg_a ^ neg_b) ? (32'd0 - quo_mag) : quo_mag;
      rem = neg_a ? (32'd0 - rem_mag) : rem_mag;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at
// launch and held in pending registers until the latency counter expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_t         state;
  logic [CNT_W-1:0]  count;
  logic [31:0]       pend_hi;
  logic [31:0]       pend_lo;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_quo;
  logic [31:0]        div_rem;
  logic [63:0]        result;

  assign prod_s = $signed({{32{numa[31]}}, numa}) * $signed({{32{numb[31]}}, numb});
  assign prod_u = {32'd0, numa} * {32'd0, numb};

  md_core_div u_div (
    .is_signed (op == MD_DIV),
    .a         (numa),
    .b         (numb),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  always_comb begin
    result = '0;
    case (op)
      MD_MULT:         result = prod_s;
      MD_MULTU:        result = prod_u;
      MD_DIV, MD_DIVU: result = {div_rem, div_quo};
      default:         result = '0;
    endcase
  end

  // Handshake: start is a one-cycle request accepted only while busy is low;
  // busy stays high from the launch edge until the cycle HI/LO hold the result,
  // and any start seen while busy is high is dropped.
  assign md_stall = busy | (start & md_is_long(op));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MD_IDLE;
      busy    <= 1'b0;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                pend_hi <= result[63:32];
                pend_lo <= result[31:0];
                count   <= (op <= MD_MULTU) ? MULT_LOAD : DIV_LOAD;
                state   <= MD_RUN;
                busy    <= 1'b1;
              end
              MD_MTHI: hi <= numa;
              MD_MTLO: lo <= numa;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          if (count == '0) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= MD_IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a driver pushes expected HI/LO and busy length,
// a monitor pops and compares whenever busy falls.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] numa;
  logic [31:0] numb;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors;
  int checks;

  logic [63:0] exp_q[$];
  int          len_q[$];
  logic        busy_prev;
  int          run_len;

  md_unit dut (
    .clk      (clk),
    .reset    (rst),
    .start    (start),
    .op       (op),
    .numa     (numa),
    .numb     (numb),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
      run_len   = 0;
    end else begin
      if (busy) run_len++;
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", {hi, lo}, 64'hx);
        end else begin
          chk("hilo", {hi, lo}, exp_q.pop_front());
          chk("busy_len", 64'(run_len), 64'(len_q.pop_front()));
        end
        run_len = 0;
      end
      busy_prev = busy;
    end
  end

  // Driver tasks
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    numa  = a;
    numb  = b;
    #1;
    chk("md_stall_launch", 64'(md_stall), 64'(o <= MD_DIVU));
    @(negedge clk);
    start = 1'b0;
    op    = MD_NOP;
    numa  = $urandom;
    numb  = $urandom;
  endtask

  task automatic expect_op(input logic [31:0] e_hi, input logic [31:0] e_lo, input int len);
    exp_q.push_back({e_hi, e_lo});
    len_q.push_back(len);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after 40 cycles, required 0", busy);
    end
  endtask

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input int len);
    expect_op(e_hi, e_lo, len);
    launch(o, a, b);
    wait_idle();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    busy_prev = 1'b0;
    run_len   = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = MD_NOP;
    numa  = '0;
    numb  = '0;
    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_stall", 64'(md_stall), 64'd0);
    rst = 1'b0;

    run_md(MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run_md(MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_md(MD_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 10);
    run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10);
    run_md(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10);
    run_md(MD_DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, 10);
    run_md(MD_DIVU,  32'hFFFF_FFFF, 32'd2,        32'd1,         32'h7FFF_FFFF, 10);
    run_md(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        5);

    // MTHI / MTLO commit on the launch edge without a busy period
    launch(MD_MTHI, 32'h1234_5678, 32'hDEAD_BEEF);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'd0);
    launch(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);

    // op 6/7 leave everything alone
    launch(3'd7, 32'h5555_5555, 32'h1);
    chk("nop_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
    chk("nop_busy", 64'(busy), 64'd0);

    // start while busy is ignored; md_stall covers launch cycle plus 5
    expect_op(32'd0, 32'd42, 5);
    @(negedge clk);
    start = 1'b1; op = MD_MULT; numa = 32'd6; numb = 32'd7;
    #1;
    chk("stall_c0", 64'(md_stall), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      op    = (i == 2) ? MD_DIV : MD_NOP;
      numa  = $urandom;
      numb  = $urandom_range(1, 100);
      #1;
      chk($sformatf("stall_c%0d", i), 64'(md_stall), 64'd1);
      if (i == 3) chk("hilo_held_run", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("stall_after", 64'(md_stall), 64'd0);
    chk("ignored_busy", 64'(busy), 64'd0);
    repeat (12) @(negedge clk);
    chk("no_second_run", 64'(busy), 64'd0);

    // reset during a divide abandons it
    launch(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);
    exp_q.delete();
    len_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_reset_hilo", {hi, lo}, 64'd0);

    run_md(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage.
- Consumes the forwarded E-stage operands (rs and rt after the E-stage bypass muxes) and owns the HI/LO registers.
- Produces a busy/stall request for the hazard controller; the controller stalls F/D while an MD op is in flight and a dependent MD instruction sits in D.
- Results are read by MFHI/MFLO through the E-stage result path.

Parameters:
- MULT_CYCLES, 5, cycles from launch to HI/LO commit for MULT/MULTU (≥1)
- DIV_CYCLES, 10, cycles from launch to HI/LO commit for DIV/DIVU (≥1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; E-stage instruction is an MD op (decoded from ir_e by controller)
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
- numa  in  32  forwarded rs (E stage)
- numb  in  32  forwarded rt (E stage)
- busy  out  1  op in flight (registered)
- md_stall  out  1  busy | (start & op<=3); hazard controller ORs into stall
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (async, immediate): hi=0, lo=0, busy=0, count=0, pending regs=0, state=IDLE. Reset mid-operation abandons the op; HI/LO stay 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, count decrements each cycle.
- Launch (IDLE, start=1, op 0..3, rising edge):
  - Compute the 64-bit result combinationally from numa/numb; latch into pend_hi/pend_lo.
  - Load count = MULT_CYCLES-1 (op 0,1) or DIV_CYCLES-1 (op 2,3); go to RUN.
  - If the loaded value is 0, commit on the next edge.
- RUN: at the edge where count==0, hi<=pend_hi, lo<=pend_lo, return to IDLE.
  - busy is therefore high for exactly N cycles after the launch edge (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible on the first cycle busy=0.
- MULT: {hi,lo} = signed(numa)*signed(numb), 64-bit two's complement.
- MULTU: unsigned 64-bit product.
- DIV: lo = truncated signed quotient (rounds toward zero), hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (both signed and unsigned): lo=32'hFFFF_FFFF, hi=numa.
- Signed overflow (numa=32'h8000_0000, numb=32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- MTHI/MTLO in IDLE: hi<=numa (or lo<=numa) on that edge; busy stays 0; no RUN state.
- start while busy=1, any op: ignored; HI/LO and count unchanged. The controller guarantees this never happens; the bench checks it is harmless.
- op 6/7 with start: no effect.
- Operands are sampled only at the launch edge; later changes on numa/numb during RUN have no effect.
- md_stall is combinational. It is asserted on the launch cycle itself so that an MD/MFHI/MFLO instruction in D stalls from that cycle on.
- hi/lo are pure register outputs with no same-cycle bypass. An MTHI followed by MFHI one cycle later reads the new value, because the MTHI has committed by then.

Decomposition:
- Shared package/header: op encodings (MD_MULT..MD_MTLO, MD_NOP), default cycle counts.
- One natural sub-module, md_core_div: combinational signed/unsigned quotient/remainder with the divide-by-zero and overflow rules above. It is reusable if an iterative divider replaces it later.
- Multiply stays inline.
- Control (counter, state, commit) stays in md_unit.

Test Plan:
- MULT numa=32'hFFFF_FFFE (-2), numb=3 → busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- MULTU numa=numb=32'hFFFF_FFFF → after 5 cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV numa=-7 (32'hFFFF_FFF9), numb=2 → busy 10 cycles; lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU 7/0 → lo=32'hFFFF_FFFF, hi=7.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF → lo=32'h8000_0000, hi=0. MTHI numa=32'h1234_5678 in IDLE → hi updated next cycle, busy never rises.
- Launch MULT, then pulse start with DIV at cycle 2 while busy → ignored; MULT result committed at cycle 5, no second busy period. md_stall=1 on the launch cycle and the following 5 cycles.
- Launch DIV, assert reset at cycle 4 → busy=0, hi=lo=0 immediately. A later MULTU 3*4 gives lo=12, hi=0 after 5 cycles.
